// File: rtl/speck_pkg.sv
// Shared SPECK128/128 constants, schedule state type and rotation helpers.
// The round-encrypt stage imports the same rotation functions.
package speck_pkg;

  localparam int WORD   = 64;
  localparam int ROUNDS = 32;
  localparam int IDX_W  = $clog2(ROUNDS);
  localparam int ALPHA  = 8;
  localparam int BETA   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } sched_state_e;

  // n == 0 is safe: the complementary shift by WORD yields zero.
  function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int unsigned n);
    ror = (x >> n) | (x << (WORD - n));
  endfunction

  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] x, input int unsigned n);
    rol = (x << n) | (x >> (WORD - n));
  endfunction

endpackage

// File: rtl/speck_key_step.sv
// One SPECK128 key-schedule step: (k, l, i) -> (k', l'), purely combinational.
module speck_key_step
  import speck_pkg::*;
(
  input  logic [WORD-1:0]  k,
  input  logic [WORD-1:0]  l,
  input  logic [IDX_W-1:0] i,
  output logic [WORD-1:0]  k_next,
  output logic [WORD-1:0]  l_next
);

  // The 64-bit add wraps; the carry out is intentionally dropped.
  assign l_next = (k + ror(l, ALPHA)) ^ WORD'(i);
  assign k_next = rol(k, BETA) ^ l_next;

endmodule

// File: rtl/speck_key_schedule.sv
// Expands a 128-bit SPECK key into ROUNDS subkeys held in a flop register file,
// one subkey per cycle, with a registered read port usable in every state.
module speck_key_schedule #(
  parameter int ROUNDS = speck_pkg::ROUNDS,
  parameter int WORD   = speck_pkg::WORD,
  parameter int IDX_W  = speck_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [2*WORD-1:0] key,
  output logic              busy,
  output logic              sched_valid,
  output logic              done,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD-1:0]   rd_subkey,
  output logic              rd_valid,
  output logic              rd_miss,
  output logic [1:0]        fsm_state
);

  import speck_pkg::*;

  localparam int CNT_W = IDX_W + 1;

  sched_state_e state_q, state_d;

  logic [WORD-1:0]  k_q, l_q;
  logic [IDX_W-1:0] i_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [WORD-1:0]  k_next, l_next;

  logic             accept, step, last_step;
  logic             sk_we;
  logic [IDX_W-1:0] sk_widx;
  logic [WORD-1:0]  sk_wdata;

  logic [WORD-1:0]  sk [ROUNDS];

  speck_key_step u_step (
    .k      (k_q),
    .l      (l_q),
    .i      (i_q),
    .k_next (k_next),
    .l_next (l_next)
  );

  // Key handshake: a key transfers on any rising edge where key_valid && key_ready;
  // key_ready depends only on state (low in EXPAND), so the source holds key stable
  // until it sees key_ready high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          accept  = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (i_q == IDX_W'(ROUNDS - 2)) begin
          last_step = 1'b1;
          state_d   = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_ready = (state_q != EXPAND);
  assign busy      = (state_q == EXPAND);
  assign fsm_state = state_q;

  // Accept writes k0 into slot 0; each expansion step writes the slot after i.
  always_comb begin
    sk_we    = accept | step;
    sk_widx  = accept ? '0 : i_q + IDX_W'(1);
    sk_wdata = accept ? key[WORD-1:0] : k_next;
  end

  always_ff @(posedge clk) begin
    if (sk_we) sk[sk_widx] <= sk_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      l_q         <= '0;
      i_q         <= '0;
      wr_cnt_q    <= '0;
      sched_valid <= 1'b0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_miss     <= 1'b0;
      rd_subkey   <= '0;
    end else begin
      done <= last_step;
      if (accept) begin
        k_q         <= key[WORD-1:0];
        l_q         <= key[2*WORD-1:WORD];
        i_q         <= '0;
        wr_cnt_q    <= CNT_W'(1);
        sched_valid <= 1'b0;
      end else if (step) begin
        k_q      <= k_next;
        l_q      <= l_next;
        i_q      <= i_q + IDX_W'(1);
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        if (last_step) sched_valid <= 1'b1;
      end
      // Reads see the pre-edge file and count, so a same-slot write is not visible yet.
      rd_valid <= rd_en;
      rd_miss  <= rd_en && ({1'b0, rd_idx} >= wr_cnt_q);
      if (rd_en) rd_subkey <= sk[rd_idx];
    end
  end

endmodule

// File: tb/tb_speck_key_schedule.sv
// Directed + randomized bench for speck_key_schedule against a plain-arithmetic
// SPECK128/128 key-expansion model.
module tb_speck_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         busy;
  logic         sched_valid;
  logic         done;
  logic         rd_en;
  logic [4:0]   rd_idx;
  logic [63:0]  rd_subkey;
  logic         rd_valid;
  logic         rd_miss;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_sk [32];
  logic [63:0] exp_q [$];

  speck_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key         (key),
    .busy        (busy),
    .sched_valid (sched_valid),
    .done        (done),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_subkey   (rd_subkey),
    .rd_valid    (rd_valid),
    .rd_miss     (rd_miss),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model: SPECK128/128 schedule straight from the cipher definition.
  function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] m_rol(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic void model(input logic [127:0] mk);
    logic [63:0] k, l;
    k = mk[63:0];
    l = mk[127:64];
    exp_sk[0] = k;
    for (int r = 0; r < 31; r++) begin
      l = (k + m_ror(l, 8)) ^ 64'(r);
      k = m_rol(k, 3) ^ l;
      exp_sk[r+1] = k;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_bit({tag, "_key_ready"}, key_ready, 1'b1);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_sched_valid"}, sched_valid, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_rd_valid"}, rd_valid, 1'b0);
    check_bit({tag, "_rd_miss"}, rd_miss, 1'b0);
    check_word({tag, "_rd_subkey"}, rd_subkey, 64'h0);
  endtask

  task automatic load_key(input logic [127:0] k);
    key_valid = 1'b1;
    key       = k;
    tick();
    key_valid = 1'b0;
  endtask

  // Bounded wait for done; expects exp_edges more edges with busy high the whole time.
  task automatic wait_done(input string tag, input int exp_edges);
    int n = 0;
    int busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    check_word({tag, "_done_latency"}, 64'(n), 64'(exp_edges));
    check_word({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_edges));
    check_bit({tag, "_sched_valid_at_done"}, sched_valid, 1'b1);
    check_bit({tag, "_busy_at_done"}, busy, 1'b0);
    tick();
    check_bit({tag, "_done_one_pulse"}, done, 1'b0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_en  = 1'b1;
      rd_idx = 5'(i);
      exp_q.push_back(exp_sk[i]);
      tick();
      check_bit({tag, "_rd_valid"}, rd_valid, 1'b1);
      check_bit({tag, "_rd_miss"}, rd_miss, 1'b0);
      check_word($sformatf("%s_sk%0d", tag, i), rd_subkey, exp_q.pop_front());
    end
    rd_en = 1'b0;
    tick();
    check_bit({tag, "_rd_valid_drop"}, rd_valid, 1'b0);
  endtask

  initial begin
    logic [127:0] ka, kb;

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    tick();

    // Published test vector, with reads issued mid-expansion.
    ka = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
    model(ka);
    load_key(ka);
    check_bit("vec_accept_busy", busy, 1'b1);
    check_bit("vec_accept_ready", key_ready, 1'b0);
    check_bit("vec_accept_sched_valid", sched_valid, 1'b0);
    tick();
    rd_en  = 1'b1;
    rd_idx = 5'd5;
    tick();
    check_bit("mid_idx5_valid", rd_valid, 1'b1);
    check_bit("mid_idx5_miss", rd_miss, 1'b1);
    rd_idx = 5'd1;
    tick();
    check_bit("mid_idx1_valid", rd_valid, 1'b1);
    check_bit("mid_idx1_miss", rd_miss, 1'b0);
    check_word("mid_idx1_data", rd_subkey, 64'h37253b31171d0309);
    rd_en = 1'b0;
    wait_done("vec", 28);
    read_all("vec");

    // Second key held valid through EXPAND.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    load_key(ka);
    key_valid = 1'b1;
    key       = kb;
    begin
      int n = 0;
      while (!key_ready && n < 100) begin
        tick();
        n++;
      end
      check_word("hold_ready_low_cycles", 64'(n), 64'd31);
    end
    check_bit("hold_done_at_ready", done, 1'b1);
    check_bit("hold_sched_valid_at_ready", sched_valid, 1'b1);
    rd_en  = 1'b1;
    rd_idx = 5'd0;
    tick();
    check_bit("hold_accept_sched_drop", sched_valid, 1'b0);
    check_bit("hold_accept_ready_low", key_ready, 1'b0);
    check_bit("rbw_valid", rd_valid, 1'b1);
    check_bit("rbw_miss", rd_miss, 1'b0);
    check_word("rbw_old_k0", rd_subkey, ka[63:0]);
    key_valid = 1'b0;
    rd_en     = 1'b0;
    wait_done("hold2", 31);
    model(kb);
    read_all("hold2");

    // All-ones key exercises the add wrap and rotation edges.
    model({128{1'b1}});
    load_key({128{1'b1}});
    wait_done("ones", 31);
    read_all("ones");

    for (int t = 0; t < 3; t++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      model(ka);
      load_key(ka);
      wait_done($sformatf("rnd%0d", t), 31);
      read_all($sformatf("rnd%0d", t));
    end

    // Asynchronous reset at cycle 10 of expansion.
    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (9) tick();
    rd_en  = 1'b1;
    rd_idx = 5'd0;
    tick();
    rd_en = 1'b0;
    check_bit("pre_rst_busy", busy, 1'b1);
    check_bit("pre_rst_rd_valid", rd_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    #2 rst_n = 1'b1;
    tick();
    rd_en  = 1'b1;
    rd_idx = 5'd3;
    tick();
    check_bit("post_rst_idx3_valid", rd_valid, 1'b1);
    check_bit("post_rst_idx3_miss", rd_miss, 1'b1);
    rd_idx = 5'd0;
    tick();
    check_bit("post_rst_idx0_miss", rd_miss, 1'b1);
    rd_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
